// File: rtl/pac_req_stage_if.sv
// Request/grant bundle between the PAC request front-end and the argmax/tie-break logic.
interface pac_req_stage_if #(
    parameter int N = 4,
    parameter int W = 3
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]     req_i;
    logic [N*W-1:0]   weight_i;
    logic             grant_valid_i;
    logic [IDX_W-1:0] grant_idx_i;
    logic             clr_i;
    logic [N-1:0]     contenders_o;
    logic [N*W-1:0]   eff_weight_o;
    logic [IDX_W-1:0] rr_ptr_o;
    logic [N-1:0]     overflow_o;
    logic             grant_err_o;

    modport master (
        output req_i, weight_i, grant_valid_i, grant_idx_i, clr_i,
        input  contenders_o, eff_weight_o, rr_ptr_o, overflow_o, grant_err_o
    );

    modport slave (
        input  req_i, weight_i, grant_valid_i, grant_idx_i, clr_i,
        output contenders_o, eff_weight_o, rr_ptr_o, overflow_o, grant_err_o
    );
endinterface

// File: rtl/pac_req_stage.sv
// PAC arbiter request front-end: per-requester pending counts, aging boost, rr pointer.
// Latency: request visible on contenders one cycle after sampling; grant retires at its edge.
// Backpressure: none; a request into a full counter is dropped and flagged in overflow_o.
module pac_req_stage #(
    parameter int N      = 4,
    parameter int W      = 3,
    parameter int CNT_W  = 2,
    parameter int AGE_W  = 4,
    parameter int AGE_SH = 2
) (
    input  logic           clk,
    input  logic           rst,
    pac_req_stage_if.slave bus
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int SUM_W = ((W > AGE_W) ? W : AGE_W) + 1;
    localparam logic [SUM_W-1:0] EFF_MAX = SUM_W'((2 ** W) - 1);

    logic [N-1:0]     pend_nz;
    logic [N-1:0]     gnt_sel;
    logic [N-1:0]     ovf_set;
    logic [N-1:0]     ovf_q;
    logic [N*W-1:0]   eff_w;
    logic             valid_grant;
    logic             grant_err_q;
    logic [IDX_W-1:0] rr_q;
    logic [IDX_W-1:0] rr_d;

    // An index with no decode bit (>= N) can never qualify as a valid grant.
    assign valid_grant = bus.grant_valid_i && (|(gnt_sel & pend_nz));

    for (genvar k = 0; k < N; k++) begin : g_req
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [AGE_W-1:0] age_q, age_d;
        logic [SUM_W-1:0] sum;
        logic             gnt_k;
        logic             req_k;

        assign gnt_sel[k] = (bus.grant_idx_i == IDX_W'(k));
        assign gnt_k      = valid_grant && gnt_sel[k];
        assign req_k      = bus.req_i[k];
        assign pend_nz[k] = (cnt_q != '0);

        always_comb begin
            cnt_d      = cnt_q;
            ovf_set[k] = 1'b0;
            if (req_k && !gnt_k) begin
                if (cnt_q == '1) ovf_set[k] = 1'b1;
                else             cnt_d = cnt_q + CNT_W'(1);
            end else if (gnt_k && !req_k) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        // Age only advances once the count was already nonzero at this edge.
        always_comb begin
            age_d = age_q;
            if (gnt_k || (cnt_d == '0))          age_d = '0;
            else if (pend_nz[k] && age_q != '1)  age_d = age_q + AGE_W'(1);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
                age_q <= '0;
            end else begin
                cnt_q <= cnt_d;
                age_q <= age_d;
            end
        end

        assign sum = SUM_W'(bus.weight_i[k*W +: W]) + SUM_W'(age_q >> AGE_SH);
        assign eff_w[k*W +: W] = (sum > EFF_MAX) ? {W{1'b1}} : sum[W-1:0];
    end

    assign rr_d = (bus.grant_idx_i == IDX_W'(N - 1)) ? '0 : bus.grant_idx_i + IDX_W'(1);

    // Sticky flags: a set event in the same cycle as clr_i wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q       <= '0;
            grant_err_q <= 1'b0;
            rr_q        <= '0;
        end else begin
            ovf_q       <= (ovf_q & ~{N{bus.clr_i}}) | ovf_set;
            grant_err_q <= (grant_err_q && !bus.clr_i) || (bus.grant_valid_i && !valid_grant);
            if (valid_grant) rr_q <= rr_d;
        end
    end

    assign bus.contenders_o = pend_nz;
    assign bus.eff_weight_o = eff_w;
    assign bus.rr_ptr_o     = rr_q;
    assign bus.overflow_o   = ovf_q;
    assign bus.grant_err_o  = grant_err_q;
endmodule

// File: tb/tb_pac_req_stage.sv
// Directed bench for pac_req_stage: inputs change at negedge, outputs checked at the following negedge.
module tb_pac_req_stage;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    localparam logic [11:0] WEIGHTS = 12'h6A9; // w3=3 w2=2 w1=5 w0=1

    pac_req_stage_if #(.N(4), .W(3)) bus ();

    pac_req_stage #(.N(4), .W(3), .CNT_W(2), .AGE_W(4), .AGE_SH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input logic [3:0] req, input logic gv, input logic [1:0] gi, input logic clr);
        bus.req_i         = req;
        bus.grant_valid_i = gv;
        bus.grant_idx_i   = gi;
        bus.clr_i         = clr;
        tick();
        bus.req_i         = '0;
        bus.grant_valid_i = 1'b0;
        bus.grant_idx_i   = '0;
        bus.clr_i         = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [11:0] eff;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.req_i         = '0;
        bus.weight_i      = WEIGHTS;
        bus.grant_valid_i = 1'b0;
        bus.grant_idx_i   = '0;
        bus.clr_i         = 1'b0;

        @(negedge clk);
        chk("rst_contenders", 32'(bus.contenders_o), 32'h0);
        chk("rst_rr", 32'(bus.rr_ptr_o), 32'h0);
        chk("rst_ovf", 32'(bus.overflow_o), 32'h0);
        chk("rst_err", 32'(bus.grant_err_o), 32'h0);
        chk("rst_eff", 32'(bus.eff_weight_o), 32'(WEIGHTS));
        rst = 1'b0;

        // two requesters, one cycle latency
        step(4'b0101, 1'b0, 2'd0, 1'b0);
        chk("req0101_contenders", 32'(bus.contenders_o), 32'h5);
        chk("req0101_eff", 32'(bus.eff_weight_o), 32'(WEIGHTS));
        chk("req0101_rr", 32'(bus.rr_ptr_o), 32'h0);
        step(4'b0000, 1'b1, 2'd0, 1'b0);
        chk("g0_contenders", 32'(bus.contenders_o), 32'h4);
        chk("g0_rr", 32'(bus.rr_ptr_o), 32'h1);
        step(4'b0000, 1'b1, 2'd2, 1'b0);
        chk("g2_contenders", 32'(bus.contenders_o), 32'h0);
        chk("g2_rr", 32'(bus.rr_ptr_o), 32'h3);

        // counter saturation and overflow
        for (int i = 0; i < 3; i++) step(4'b0100, 1'b0, 2'd0, 1'b0);
        chk("sat3_ovf", 32'(bus.overflow_o), 32'h0);
        step(4'b0100, 1'b0, 2'd0, 1'b0);
        chk("sat4_ovf", 32'(bus.overflow_o), 32'h4);
        chk("sat4_contenders", 32'(bus.contenders_o), 32'h4);
        step(4'b0000, 1'b1, 2'd2, 1'b0);
        chk("drain1_contenders", 32'(bus.contenders_o), 32'h4);
        chk("drain1_rr", 32'(bus.rr_ptr_o), 32'h3);
        step(4'b0000, 1'b1, 2'd2, 1'b0);
        chk("drain2_contenders", 32'(bus.contenders_o), 32'h4);
        chk("drain2_rr", 32'(bus.rr_ptr_o), 32'h3);
        step(4'b0000, 1'b1, 2'd2, 1'b0);
        chk("drain3_contenders", 32'(bus.contenders_o), 32'h0);
        chk("drain3_rr", 32'(bus.rr_ptr_o), 32'h3);
        chk("drain_err", 32'(bus.grant_err_o), 32'h0);
        chk("drain_ovf_sticky", 32'(bus.overflow_o), 32'h4);
        step(4'b0000, 1'b0, 2'd0, 1'b1);
        chk("clr_ovf", 32'(bus.overflow_o), 32'h0);

        // aging boost on requester 1 (weight 5)
        step(4'b0010, 1'b0, 2'd0, 1'b0);
        eff = bus.eff_weight_o;
        chk("age0_eff1", 32'(eff[5:3]), 32'd5);
        idle(3);
        eff = bus.eff_weight_o;
        chk("age3_eff1", 32'(eff[5:3]), 32'd5);
        idle(1);
        eff = bus.eff_weight_o;
        chk("age4_eff1", 32'(eff[5:3]), 32'd6);
        idle(4);
        eff = bus.eff_weight_o;
        chk("age8_eff1", 32'(eff[5:3]), 32'd7);
        idle(4);
        eff = bus.eff_weight_o;
        chk("age12_eff1_sat", 32'(eff[5:3]), 32'd7);
        chk("age12_eff_others", 32'({eff[11:6], eff[2:0]}), 32'({6'b011_010, 3'b001}));
        step(4'b0000, 1'b1, 2'd1, 1'b0);
        eff = bus.eff_weight_o;
        chk("g1_eff1", 32'(eff[5:3]), 32'd5);
        chk("g1_rr", 32'(bus.rr_ptr_o), 32'h2);
        chk("g1_contenders", 32'(bus.contenders_o), 32'h0);

        // simultaneous request and grant on requester 0 (weight 1)
        step(4'b0001, 1'b0, 2'd0, 1'b0);
        idle(5);
        eff = bus.eff_weight_o;
        chk("age5_eff0", 32'(eff[2:0]), 32'd2);
        step(4'b0001, 1'b1, 2'd0, 1'b0);
        eff = bus.eff_weight_o;
        chk("same_contenders", 32'(bus.contenders_o), 32'h1);
        chk("same_eff0", 32'(eff[2:0]), 32'd1);
        chk("same_rr", 32'(bus.rr_ptr_o), 32'h1);
        chk("same_ovf", 32'(bus.overflow_o), 32'h0);
        step(4'b0000, 1'b1, 2'd0, 1'b0);
        chk("same_drain_contenders", 32'(bus.contenders_o), 32'h0);

        // grants with nothing pending
        step(4'b0000, 1'b1, 2'd3, 1'b0);
        chk("badg_err", 32'(bus.grant_err_o), 32'h1);
        chk("badg_rr", 32'(bus.rr_ptr_o), 32'h1);
        chk("badg_contenders", 32'(bus.contenders_o), 32'h0);
        step(4'b0000, 1'b0, 2'd0, 1'b1);
        chk("badg_clr", 32'(bus.grant_err_o), 32'h0);
        step(4'b0000, 1'b1, 2'd3, 1'b1);
        chk("badg_set_wins", 32'(bus.grant_err_o), 32'h1);
        chk("badg2_rr", 32'(bus.rr_ptr_o), 32'h1);
        step(4'b0000, 1'b0, 2'd0, 1'b1);
        chk("badg_clr2", 32'(bus.grant_err_o), 32'h0);

        // counts 2,1,3,0 with rr=2, then async reset mid-cycle
        step(4'b0111, 1'b0, 2'd0, 1'b0);
        step(4'b0111, 1'b0, 2'd0, 1'b0);
        step(4'b0100, 1'b1, 2'd1, 1'b0);
        chk("pre_rst_contenders", 32'(bus.contenders_o), 32'h7);
        chk("pre_rst_rr", 32'(bus.rr_ptr_o), 32'h2);
        step(4'b0000, 1'b1, 2'd1, 1'b0);
        chk("pre_rst_cnt1_drained", 32'(bus.contenders_o), 32'h5);
        step(4'b0010, 1'b0, 2'd0, 1'b0);
        chk("pre_rst_restored", 32'(bus.contenders_o), 32'h7);
        #2 rst = 1'b1;
        #1;
        chk("arst_contenders", 32'(bus.contenders_o), 32'h0);
        chk("arst_rr", 32'(bus.rr_ptr_o), 32'h0);
        chk("arst_ovf", 32'(bus.overflow_o), 32'h0);
        chk("arst_err", 32'(bus.grant_err_o), 32'h0);
        chk("arst_eff", 32'(bus.eff_weight_o), 32'(WEIGHTS));
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("post_rst_contenders", 32'(bus.contenders_o), 32'h0);
        chk("post_rst_eff", 32'(bus.eff_weight_o), 32'(WEIGHTS));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
